// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and alu_arbiter.
// master: requester side, slave: arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_lhs;
  logic [WIDTH-1:0] req0_rhs;
  logic [3:0]       req0_funct;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_lhs;
  logic [WIDTH-1:0] req1_rhs;
  logic [3:0]       req1_funct;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_y;
  logic             rsp0_zero;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_y;
  logic             rsp1_zero;

  modport master (
    output req0_valid, req0_lhs, req0_rhs, req0_funct,
    output req1_valid, req1_lhs, req1_rhs, req1_funct,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_y, rsp0_zero,
    input  rsp1_valid, rsp1_y, rsp1_zero
  );

  modport slave (
    input  req0_valid, req0_lhs, req0_rhs, req0_funct,
    input  req1_valid, req1_lhs, req1_rhs, req1_funct,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_y, rsp0_zero,
    output rsp1_valid, rsp1_y, rsp1_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Ports: clk, rst_n (sync, low), bus (slave), alu_* side, busy, grant.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_lhs,
  output logic [WIDTH-1:0] alu_rhs,
  output logic [3:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             busy,
  output logic             grant
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lhs_q;
  logic [WIDTH-1:0] rhs_q;
  logic [3:0]       funct_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;

  logic any_req;
  logic win;
  logic accept;
  logic rsp_take;

  // Contention goes to the port that did not win last time.
  assign any_req = bus.req0_valid | bus.req1_valid;
  assign win     = (bus.req0_valid & bus.req1_valid)
                 ? ~grant : bus.req1_valid;
  assign accept  = rst_n & (state == IDLE) & any_req;

  assign bus.req0_ready = accept & ~win;
  assign bus.req1_ready = accept & win;

  assign rsp_take = grant ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= 1'b1;
      lhs_q   <= '0;
      rhs_q   <= '0;
      funct_q <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= win;
            lhs_q   <= win ? bus.req1_lhs : bus.req0_lhs;
            rhs_q   <= win ? bus.req1_rhs : bus.req0_rhs;
            funct_q <= win ? bus.req1_funct : bus.req0_funct;
            state   <= EXEC;
          end
        end
        EXEC: begin
          y_q    <= alu_y;
          zero_q <= alu_zero;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_take) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_lhs   = lhs_q;
  assign alu_rhs   = rhs_q;
  assign alu_funct = funct_q;

  assign busy = (state != IDLE);

  assign bus.rsp0_valid = (state == RESP) & ~grant;
  assign bus.rsp1_valid = (state == RESP) & grant;
  assign bus.rsp0_y     = y_q;
  assign bus.rsp1_y     = y_q;
  assign bus.rsp0_zero  = zero_q;
  assign bus.rsp1_zero  = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU.
// Directed phases followed by randomized transactions.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_lhs;
  logic [31:0] alu_rhs;
  logic [3:0]  alu_funct;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        busy;
  logic        grant;

  int checks = 0;
  int errors = 0;
  bit exp_grant;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_lhs   (alu_lhs),
    .alu_rhs   (alu_rhs),
    .alu_funct (alu_funct),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero),
    .busy      (busy),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(
    input logic [31:0] l,
    input logic [31:0] r,
    input logic [3:0]  f
  );
    case (f)
      4'b0000: return l + r;
      4'b1000: return l - r;
      4'b0111: return l & r;
      4'b0110: return l | r;
      4'b0100: return l ^ r;
      default: return l << r[4:0];
    endcase
  endfunction

  assign alu_y    = ref_alu(alu_lhs, alu_rhs, alu_funct);
  assign alu_zero = (alu_y == 32'd0);

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input bit          v0,
    input bit          v1,
    input logic [31:0] l0,
    input logic [31:0] r0,
    input logic [3:0]  f0,
    input logic [31:0] l1,
    input logic [31:0] r1,
    input logic [3:0]  f1,
    input bit          keep,
    input int          hold
  );
    bit          w;
    logic [31:0] el;
    logic [31:0] er;
    logic [3:0]  ef;
    logic [31:0] ey;
    bus.req0_valid = v0;
    bus.req0_lhs   = l0;
    bus.req0_rhs   = r0;
    bus.req0_funct = f0;
    bus.req1_valid = v1;
    bus.req1_lhs   = l1;
    bus.req1_rhs   = r1;
    bus.req1_funct = f1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    w  = (v0 && v1) ? !exp_grant : v1;
    el = w ? l1 : l0;
    er = w ? r1 : r0;
    ef = w ? f1 : f0;
    ey = ref_alu(el, er, ef);
    #1;
    chk("idle_req0_ready", bus.req0_ready, v0 && !w);
    chk("idle_req1_ready", bus.req1_ready, v1 && w);
    tick();
    exp_grant = w;
    if (!keep) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    #1;
    chk("exec_busy", busy, 1'b1);
    chk("exec_grant", grant, w);
    chk("exec_alu_lhs", alu_lhs, el);
    chk("exec_alu_rhs", alu_rhs, er);
    chk("exec_alu_funct", alu_funct, ef);
    chk("exec_req_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    chk("exec_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    tick();
    for (int i = 0; i <= hold; i++) begin
      if (w) bus.rsp0_ready = 1'b1;
      else   bus.rsp1_ready = 1'b1;
      #1;
      chk("resp_valid", {bus.rsp0_valid, bus.rsp1_valid},
          w ? 2'b01 : 2'b10);
      chk("resp_y0", bus.rsp0_y, ey);
      chk("resp_y1", bus.rsp1_y, ey);
      chk("resp_zero", bus.rsp0_zero, ey == 32'd0);
      chk("resp_zero1", bus.rsp1_zero, ey == 32'd0);
      chk("resp_busy", busy, 1'b1);
      chk("resp_req_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
      if (i < hold) tick();
    end
    if (w) bus.rsp1_ready = 1'b1;
    else   bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    chk("done_busy", busy, 1'b0);
    chk("done_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
  endtask

  logic [3:0] codes [6] = '{4'b0000, 4'b1000, 4'b0111,
                            4'b0110, 4'b0100, 4'b0001};

  initial begin
    bit [1:0]    vv;
    logic [31:0] l0, r0, l1, r1;
    logic [3:0]  f0, f1;

    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_lhs = 32'h11; bus.req0_rhs = 32'h22;
    bus.req0_funct = 4'b0000;
    bus.req1_lhs = 32'h300; bus.req1_rhs = 32'h100;
    bus.req1_funct = 4'b1000;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    chk("rst_req_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    tick();
    tick();
    exp_grant = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 1'b1);
    chk("rst_alu_lhs", alu_lhs, 32'd0);
    chk("rst_alu_funct", alu_funct, 4'd0);
    chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    chk("rst_rsp_y", bus.rsp0_y, 32'd0);
    chk("rst_req_ready2", {bus.req0_ready, bus.req1_ready}, 2'b00);
    rst_n = 1'b1;

    // Continuous contention: grants alternate starting with port 0.
    for (int k = 0; k < 4; k++) begin
      run_op(1, 1, 32'h11, 32'h22, 4'b0000,
             32'h300, 32'h100, 4'b1000, 1, 0);
      chk("contention_grant", grant, (k % 2) == 1);
    end

    // Single op on port 0.
    run_op(1, 0, 32'd5, 32'd7, 4'b0000, 0, 0, 4'b0000, 0, 0);
    // Zero flag on port 1.
    run_op(0, 1, 0, 0, 4'b0000, 32'd9, 32'd9, 4'b1000, 0, 0);
    chk("zero_grant", grant, 1'b1);
    // Backpressure on port 1.
    run_op(0, 1, 0, 0, 4'b0000, 32'hF0F0, 32'h0FF0, 4'b0111, 0, 3);

    // Idle window.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
      chk("idle_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
      chk("idle_busy", busy, 1'b0);
      chk("idle_grant", grant, exp_grant);
    end

    // Reset during EXEC drops the op.
    bus.req0_valid = 1'b1;
    bus.req0_lhs = 32'hABC; bus.req0_rhs = 32'h1;
    bus.req0_funct = 4'b0000;
    #1;
    chk("mid_req0_ready", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_busy_exec", busy, 1'b1);
    chk("mid_rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    tick();
    rst_n = 1'b1;
    bus.req1_valid = 1'b0;
    exp_grant = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_grant", grant, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
    end
    run_op(1, 1, 32'h40, 32'h2, 4'b0001,
           32'h7, 32'h7, 4'b0100, 0, 0);
    chk("mid_next_grant", grant, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 30; k++) begin
      vv = 2'($urandom_range(1, 3));
      l0 = $urandom; r0 = $urandom;
      l1 = $urandom; r1 = $urandom;
      if ($urandom_range(0, 3) == 0) r0 = l0;
      if ($urandom_range(0, 3) == 0) r1 = l1;
      f0 = codes[$urandom_range(0, 5)];
      f1 = codes[$urandom_range(0, 5)];
      run_op(vv[0], vv[1], l0, r0, f0, l1, r1, f1, 0,
             $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("rand_idle_busy", busy, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
